// File: rtl/audio_pkg.sv
// Shared audio types and widths for the I2S blocks.
//   AUDIO_DATA_WIDTH : bits per channel sample
//   I2S_SLOT_WIDTH   : bit-clock periods per channel slot
//   audio_sample_t   : one two's-complement channel sample
//   audio_frame_t    : a left/right sample pair
package audio_pkg;

  localparam int unsigned AUDIO_DATA_WIDTH = 24;
  localparam int unsigned I2S_SLOT_WIDTH   = 32;

  typedef logic [AUDIO_DATA_WIDTH-1:0] audio_sample_t;

  typedef struct packed {
    audio_sample_t left;
    audio_sample_t right;
  } audio_frame_t;

endpackage

// File: rtl/i2s_clock_generator.sv
// I2S master clock generator: divides i_clock into BCLK, steps the slot index
// on BCLK falling edges and derives LRCLK from it.
//   i_clock, i_reset  : system clock, synchronous active-high reset
//   o_bit_clock       : BCLK (registered)
//   o_lr_clock        : LRCLK, 0 = left, 1 = right (registered)
//   o_fall_tick_c     : high in the cycle whose edge makes BCLK fall
//   o_frame_start_c   : fall tick on which the slot index wraps to 0
//   o_next_index_c    : slot index that takes effect on this fall tick
module i2s_clock_generator
  import audio_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDER = 4,
  parameter int unsigned SLOT_WIDTH    = I2S_SLOT_WIDTH
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  output logic                              o_bit_clock,
  output logic                              o_lr_clock,
  output logic                              o_fall_tick_c,
  output logic                              o_frame_start_c,
  output logic [$clog2(2*SLOT_WIDTH)-1:0]   o_next_index_c
);

  localparam int unsigned CNT_W = $clog2(CLOCK_DIVIDER);
  localparam int unsigned IDX_W = $clog2(2*SLOT_WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lr_q, lr_d;
  logic             terminal;
  logic             idx_last;

  // Divider, BCLK toggle, slot index and LRCLK next-state.
  always_comb begin
    terminal        = (cnt_q == CNT_W'(CLOCK_DIVIDER - 1));
    idx_last        = (idx_q == IDX_W'(2*SLOT_WIDTH - 1));
    cnt_d           = terminal ? '0 : cnt_q + CNT_W'(1);
    bclk_d          = bclk_q ^ terminal;
    o_fall_tick_c   = terminal & bclk_q;
    o_frame_start_c = o_fall_tick_c & idx_last;
    o_next_index_c  = idx_last ? '0 : idx_q + IDX_W'(1);
    idx_d           = idx_q;
    lr_d            = lr_q;
    if (o_fall_tick_c) begin
      idx_d = o_next_index_c;
      lr_d  = (o_next_index_c >= IDX_W'(SLOT_WIDTH));
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
      idx_q  <= IDX_W'(2*SLOT_WIDTH - 1);
      lr_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
      idx_q  <= idx_d;
      lr_q   <= lr_d;
    end
  end

  assign o_bit_clock = bclk_q;
  assign o_lr_clock  = lr_q;

endmodule

// File: rtl/i2s_master_transmitter.sv
// I2S master transmitter: generates BCLK/LRCLK and serializes left/right
// samples MSB first with the I2S one-bit delay. Input pairs pass through a
// single holding register that is loaded into the frame shifter at frame start.
//   i_clock, i_reset             : system clock, synchronous active-high reset
//   i_data_left/right, i_data_valid, o_data_ready : sample pair handshake
//   o_codec_bit_clock/lr_clock/dac_data           : I2S link to the codec
//   o_underrun                   : one-cycle pulse, frame started with no pair
module i2s_master_transmitter
  import audio_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDER = 4,
  parameter int unsigned DATA_WIDTH    = AUDIO_DATA_WIDTH,
  parameter int unsigned SLOT_WIDTH    = I2S_SLOT_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data_left,
  input  logic [DATA_WIDTH-1:0] i_data_right,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_codec_bit_clock,
  output logic                  o_codec_lr_clock,
  output logic                  o_codec_dac_data,
  output logic                  o_underrun
);

  localparam int unsigned IDX_W = $clog2(2*SLOT_WIDTH);

  logic             fall_tick;
  logic             frame_start;
  logic [IDX_W-1:0] next_index;

  i2s_clock_generator #(
    .CLOCK_DIVIDER (CLOCK_DIVIDER),
    .SLOT_WIDTH    (SLOT_WIDTH)
  ) u_clock_generator (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .o_bit_clock     (o_codec_bit_clock),
    .o_lr_clock      (o_codec_lr_clock),
    .o_fall_tick_c   (fall_tick),
    .o_frame_start_c (frame_start),
    .o_next_index_c  (next_index)
  );

  logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
  logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
  logic [DATA_WIDTH-1:0] shift_left_q, shift_left_d;
  logic [DATA_WIDTH-1:0] shift_right_q, shift_right_d;
  logic                  ready_q, ready_d;
  logic                  underrun_q, underrun_d;
  logic                  dac_q, dac_d;

  logic                  chan_right;
  logic [IDX_W-1:0]      pos;
  logic [IDX_W-1:0]      bit_sel;
  logic                  in_data;
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] shifted;

  // Holding register, frame load, underrun and serial data next-state.
  // ready_q low means the holding register is full.
  always_comb begin
    hold_left_d   = hold_left_q;
    hold_right_d  = hold_right_q;
    shift_left_d  = shift_left_q;
    shift_right_d = shift_right_q;
    ready_d       = ready_q;
    underrun_d    = 1'b0;
    dac_d         = dac_q;

    // Channel position of the slot index entered on this fall tick.
    chan_right = (next_index >= IDX_W'(SLOT_WIDTH));
    pos        = chan_right ? next_index - IDX_W'(SLOT_WIDTH) : next_index;
    in_data    = (pos != '0) && (pos <= IDX_W'(DATA_WIDTH));
    bit_sel    = IDX_W'(DATA_WIDTH) - pos;
    sample     = chan_right ? shift_right_q : shift_left_q;
    shifted    = sample >> bit_sel;

    // Position 0 always sends 0, so the shifter can reload on frame start.
    if (frame_start) begin
      if (!ready_q) begin
        shift_left_d  = hold_left_q;
        shift_right_d = hold_right_q;
        ready_d       = 1'b1;
      end else begin
        shift_left_d  = '0;
        shift_right_d = '0;
        underrun_d    = 1'b1;
      end
    end

    if (fall_tick) begin
      dac_d = in_data & shifted[0];
    end

    // Accept only when empty, so this never collides with a frame load.
    if (i_data_valid && ready_q) begin
      hold_left_d  = i_data_left;
      hold_right_d = i_data_right;
      ready_d      = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hold_left_q   <= '0;
      hold_right_q  <= '0;
      shift_left_q  <= '0;
      shift_right_q <= '0;
      ready_q       <= 1'b1;
      underrun_q    <= 1'b0;
      dac_q         <= 1'b0;
    end else begin
      hold_left_q   <= hold_left_d;
      hold_right_q  <= hold_right_d;
      shift_left_q  <= shift_left_d;
      shift_right_q <= shift_right_d;
      ready_q       <= ready_d;
      underrun_q    <= underrun_d;
      dac_q         <= dac_d;
    end
  end

  assign o_data_ready     = ready_q;
  assign o_underrun       = underrun_q;
  assign o_codec_dac_data = dac_q;

endmodule

// File: tb/tb_i2s_master_transmitter.sv
// Bench for i2s_master_transmitter: drives sample pairs, recovers words with
// a BCLK-rising-edge slave and compares against frame timing computed from
// the I2S frame arithmetic. A second instance runs with CLOCK_DIVIDER=2.
module tb_i2s_master_transmitter;
  import audio_pkg::*;

  localparam int SLOT = I2S_SLOT_WIDTH;

  logic          i_clock = 1'b0;
  logic          i_reset;
  audio_sample_t i_data_left, i_data_right;
  logic          i_data_valid;

  logic a_rdy, a_bclk, a_lr, a_dac, a_und;
  logic b_rdy, b_bclk, b_lr, b_dac, b_und;

  always #5 i_clock = ~i_clock;

  i2s_master_transmitter dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_data_left(i_data_left), .i_data_right(i_data_right),
    .i_data_valid(i_data_valid), .o_data_ready(a_rdy),
    .o_codec_bit_clock(a_bclk), .o_codec_lr_clock(a_lr),
    .o_codec_dac_data(a_dac), .o_underrun(a_und)
  );

  i2s_master_transmitter #(.CLOCK_DIVIDER(2)) dut2 (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_data_left(i_data_left), .i_data_right(i_data_right),
    .i_data_valid(i_data_valid), .o_data_ready(b_rdy),
    .o_codec_bit_clock(b_bclk), .o_codec_lr_clock(b_lr),
    .o_codec_dac_data(b_dac), .o_underrun(b_und)
  );

  int   sel;
  logic rdy_o, bclk_o, lr_o, dac_o, und_o;
  always_comb begin
    rdy_o  = sel != 0 ? b_rdy  : a_rdy;
    bclk_o = sel != 0 ? b_bclk : a_bclk;
    lr_o   = sel != 0 ? b_lr   : a_lr;
    dac_o  = sel != 0 ? b_dac  : a_dac;
    und_o  = sel != 0 ? b_und  : a_und;
  end

  typedef struct { int acc; audio_frame_t f; } pend_t;
  pend_t        pend_q[$];
  audio_frame_t exp_q[$];

  int n_vec = 0, n_err = 0;
  int cyc, cd;
  // slave monitor state
  logic        prev_bclk, prev_lr_rise, prev_lr_out, started;
  int          pos, last_rise, last_lr_fall;
  logic [31:0] word, left_word;
  // source state
  int            src_mode, gap_lo, gap_hi, shot_at;
  logic          shot_done;
  audio_sample_t ramp, shot_l, shot_r;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (sel %0d cycle %0d)", tag, got, exp, sel, cyc);
    end
  endtask

  function automatic logic [31:0] slot_word(audio_sample_t s);
    return {1'b0, s, 7'b0};
  endfunction

  // Frame k starts on the fall tick at 2*cd*(1 + 2*SLOT*k) cycles after reset.
  function automatic bit is_fs(int c);
    return c >= 2*cd && ((c - 2*cd) % (4*cd*SLOT)) == 0;
  endfunction

  function automatic int fs_cycle(int k);
    return 2*cd*(1 + 2*SLOT*k);
  endfunction

  task automatic reset_model();
    pend_q.delete();
    exp_q.delete();
    cyc = 0; prev_bclk = 1'b0; prev_lr_rise = 1'b1; prev_lr_out = 1'b1;
    started = 1'b0; pos = 0; word = '0; left_word = '0;
    last_rise = -1; last_lr_fall = -1; shot_done = 1'b0;
  endtask

  task automatic finish_frame();
    audio_frame_t f;
    check("right_len", 64'(pos), 64'(SLOT));
    if (exp_q.size() == 0) begin
      check("frame_expected", 64'(0), 64'(1));
    end else begin
      f = exp_q.pop_front();
      check("left_word",  64'(left_word), 64'(slot_word(f.left)));
      check("right_word", 64'(word),      64'(slot_word(f.right)));
    end
  endtask

  task automatic observe();
    pend_t p;
    logic  exp_und;
    exp_und = 1'b0;
    if (is_fs(cyc)) begin
      if (pend_q.size() > 0 && pend_q[0].acc < cyc) begin
        p = pend_q.pop_front();
        exp_q.push_back(p.f);
      end else begin
        exp_q.push_back('0);
        exp_und = 1'b1;
      end
    end
    check("underrun", 64'(und_o), 64'(exp_und));
    check("ready", 64'(rdy_o), 64'(pend_q.size() == 0));
    if (cyc == cd - 1 || cyc == cd)
      check("first_rise", 64'(bclk_o), 64'(cyc == cd));
    if (cyc == 2*cd - 1 || cyc == 2*cd)
      check("first_fall_lr", 64'(lr_o), 64'(cyc == 2*cd - 1));

    if (bclk_o && !prev_bclk) begin
      if (last_rise >= 0) check("bclk_period", 64'(cyc - last_rise), 64'(2*cd));
      last_rise = cyc;
      if (lr_o != prev_lr_rise) begin
        if (!lr_o) begin
          if (started) finish_frame();
          started = 1'b1;
        end else if (started) begin
          check("left_len", 64'(pos), 64'(SLOT));
          left_word = word;
        end
        pos = 0; word = '0;
      end
      word = {word[30:0], dac_o};
      pos++;
      prev_lr_rise = lr_o;
    end
    prev_bclk = bclk_o;

    if (lr_o != prev_lr_out) begin
      if (!lr_o) begin
        if (last_lr_fall >= 0) check("lr_period", 64'(cyc - last_lr_fall), 64'(4*cd*SLOT));
        last_lr_fall = cyc;
      end else if (last_lr_fall >= 0) begin
        check("lr_low_time", 64'(cyc - last_lr_fall), 64'(2*cd*SLOT));
      end
      prev_lr_out = lr_o;
    end
  endtask

  // Drive the inputs seen by the next edge (cycle cyc+1).
  task automatic drive_source();
    logic  want;
    pend_t p;
    want = 1'b0;
    case (src_mode)
      1: begin
        want = !((cyc + 1) >= gap_lo && (cyc + 1) < gap_hi);
        i_data_left  = ramp;
        i_data_right = ramp | 24'h800000;
      end
      2: begin
        want = !shot_done && (cyc + 1) >= shot_at;
        i_data_left  = shot_l;
        i_data_right = shot_r;
      end
      3: begin
        want = $urandom_range(0, 3) != 0;
        if (rdy_o) begin
          i_data_left  = 24'($urandom);
          i_data_right = 24'($urandom);
        end
      end
      default: want = 1'b0;
    endcase
    i_data_valid = want;
    if (want && rdy_o) begin
      p.acc = cyc + 1;
      p.f.left = i_data_left;
      p.f.right = i_data_right;
      pend_q.push_back(p);
      if (src_mode == 1) ramp = ramp + 24'd1;
      if (src_mode == 2) shot_done = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    cyc++;
    @(negedge i_clock);
    observe();
    drive_source();
  endtask

  task automatic run_to(int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(int cycles);
    @(negedge i_clock);
    i_reset = 1'b1;
    i_data_valid = 1'b0;
    repeat (cycles) @(posedge i_clock);
    @(negedge i_clock);
    check("rst_bclk", 64'(bclk_o), 64'(0));
    check("rst_lr",   64'(lr_o),   64'(1));
    check("rst_dac",  64'(dac_o),  64'(0));
    check("rst_ready", 64'(rdy_o), 64'(1));
    check("rst_und",  64'(und_o),  64'(0));
    i_reset = 1'b0;
    reset_model();
    drive_source();
  endtask

  // All frames up to the last started one must have been recovered.
  task automatic end_phase();
    check("frames_pending", 64'(exp_q.size()), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; cd = 4;
    i_reset = 1'b1; i_data_valid = 1'b0;
    i_data_left = '0; i_data_right = '0;
    src_mode = 0; gap_lo = 0; gap_hi = 0; shot_at = 0;
    ramp = 24'd1; shot_l = '0; shot_r = '0;
    reset_model();

    // idle: underrun on every frame, zero data
    src_mode = 0;
    do_reset(2);
    run_to(600);
    run_to(fs_cycle(2) + 4*cd);
    end_phase();

    // single known pair accepted on cycle 1
    src_mode = 2; shot_at = 1; shot_l = 24'hABCDEF; shot_r = 24'h123456;
    do_reset(2);
    run_to(fs_cycle(2) + 4*cd);
    end_phase();

    // continuous ramp streaming
    src_mode = 1; ramp = 24'd1; gap_lo = 0; gap_hi = 0;
    do_reset(2);
    run_to(fs_cycle(11) + 4*cd);
    end_phase();

    // withhold valid across frame 3
    src_mode = 1; gap_lo = fs_cycle(2) + 1; gap_hi = fs_cycle(3) + 1;
    do_reset(2);
    run_to(fs_cycle(6) + 4*cd);
    end_phase();

    // pair first offered on the frame-start cycle of frame 1
    src_mode = 2; shot_at = fs_cycle(1); shot_l = 24'h7FFFFF; shot_r = 24'h800001;
    do_reset(2);
    run_to(fs_cycle(3) + 4*cd);
    end_phase();

    // random data and random valid
    src_mode = 3;
    do_reset(2);
    run_to(fs_cycle(8) + 4*cd);
    end_phase();

    // one-cycle reset in the middle of the right channel with holding full
    src_mode = 1; gap_lo = 0; gap_hi = 0;
    do_reset(2);
    run_to(fs_cycle(2) + 2*cd*(SLOT + 5));
    do_reset(1);
    run_to(fs_cycle(3) + 4*cd);
    end_phase();

    // divide-by-2 instance
    sel = 1; cd = 2; src_mode = 3;
    do_reset(2);
    run_to(fs_cycle(6) + 4*cd);
    end_phase();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_master_transmitter.md
Name: i2s_master_transmitter

Overview:
- Drives the codec-facing I2S link as clock master. It generates the bit clock and LR clock from i_clock and serializes parallel 24-bit left/right samples onto the DAC data line.
- It is the counterpart of the existing I2S slave receive/transmit path, which consumes codec-supplied clocks.
- Uses: driving codecs configured as slaves, and as a codec model for the audio_processor bench.
- Parallel input uses a valid/ready handshake, double-buffered against the frame shifter.

Parameters:
- CLOCK_DIVIDER, 4, i_clock cycles per half bit-clock period (>=2).
- DATA_WIDTH, 24, sample bits per channel.
- SLOT_WIDTH, 32, bit-clock periods per channel slot (>= DATA_WIDTH+1).

Ports:
- i_clock  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_data_left  input  DATA_WIDTH  left sample, two's complement
- i_data_right  input  DATA_WIDTH  right sample
- i_data_valid  input  1  sample pair valid
- o_data_ready  output  1  holding register empty; pair accepted on valid && ready
- o_codec_bit_clock  output  1  I2S BCLK
- o_codec_lr_clock  output  1  I2S LRCLK; 0 = left, 1 = right
- o_codec_dac_data  output  1  I2S serial data
- o_underrun  output  1  one-cycle pulse: frame started with empty holding register

Behaviour:
- Clocking: one clock (i_clock); reset is synchronous and active-high (i_reset).
- Reset values: o_codec_bit_clock=0, o_codec_lr_clock=1, o_codec_dac_data=0, o_data_ready=1, o_underrun=0, holding empty, shifter zero, slot index=2*SLOT_WIDTH-1, divider count=0.
- Divider:
  - Count 0..CLOCK_DIVIDER-1, wrapping.
  - At terminal count, BCLK toggles.
  - 0->1 is a rising edge; 1->0 is a falling edge ("fall tick").
- First edges after reset release with CLOCK_DIVIDER=4: first rising edge on cycle 4, first fall tick on cycle 8.
- Slot index: advances on each fall tick, modulo 2*SLOT_WIDTH.
  - o_codec_lr_clock = (index >= SLOT_WIDTH), updated on the same fall tick.
  - Falling-edge-only outputs mean all outputs are stable at the BCLK rising edge, where the codec samples.
- Frame start: fall tick where the index wraps to 0.
  - If holding is full: left/right load into the shifter, holding becomes empty, o_data_ready=1 from the next cycle.
  - If holding is empty: the shifter loads zeros and o_underrun pulses for that cycle.
- Data (I2S, one-bit delay): at channel position p = index mod SLOT_WIDTH:
  - p=0: data=0.
  - p=1..DATA_WIDTH: data = sample bit DATA_WIDTH-p, MSB first.
  - p>DATA_WIDTH: data=0.
  - Updated on the fall tick.
- Handshake:
  - When valid && ready, both samples are captured into holding and ready deasserts the next cycle.
  - Frame-start load uses holding state from before this cycle's write. A pair accepted on the frame-start cycle is therefore not used this frame; it waits for the next frame.
  - Valid while not ready: ignored; the source must hold.
- Steady-state throughput: one pair per frame (2*SLOT_WIDTH*2*CLOCK_DIVIDER cycles = 512 at defaults).
- Reset mid-frame: all state returns to reset values on the next edge, and the current frame and holding contents are discarded.

Decomposition:
- audio_pkg holds:
  - AUDIO_DATA_WIDTH=24 and I2S_SLOT_WIDTH=32
  - typedef audio_sample_t (logic [AUDIO_DATA_WIDTH-1:0])
  - typedef audio_frame_t, a struct {left, right}
- Sub-module i2s_clock_generator:
  - Contains the divider, BCLK, slot index and LRCLK.
  - Outputs bit_clock, lr_clock, fall_tick and frame_start.
  - Reusable by future receive-master blocks.
- The top level contains holding, handshake, shifter and underrun.

Test Plan:
1. Reset, then observe 600 cycles idle at defaults -> BCLK period 8 cycles, LRCLK period 512 cycles with 50% duty; first frame start at cycle 8 asserts o_underrun for one cycle; DAC data all 0.
2. After reset, present left=0xABCDEF, right=0x123456 with valid -> accepted on cycle 1 and ready=0; at the next frame start the holding register loads and ready=1. A bench slave sampling on BCLK rising edges recovers left=0xABCDEF at positions 1..24 (first bit 1) and right=0x123456; positions 0 and 25..31 are 0.
3. Continuous streaming: source asserts valid whenever ready, with a ramp 0x000001, 0x000002, ... -> 10 consecutive frames recovered in order, o_underrun never pulses after the first frame.
4. Withhold valid for one frame mid-stream -> that frame transmits zeros, o_underrun pulses exactly once, and the following frame carries the next supplied pair.
5. Assert valid exactly on a frame-start cycle with holding empty -> underrun pulses; the pair is accepted and transmitted in the next frame, not the current one.
6. Assert i_reset for one cycle mid-right-channel, and separately run CLOCK_DIVIDER=2 -> the reset case returns to reset values next cycle with the first fall tick 2*CLOCK_DIVIDER cycles later; the divider case gives a BCLK period of 4 cycles and correct data recovery.
